// File: rtl/target_extractor_if.sv
// rtl/target_extractor_if.sv - target report stream (valid/ready) between extractor and consumer
interface target_extractor_if;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [11:0] rpt_start;
  logic [11:0] rpt_width;
  logic [11:0] rpt_peak;
  logic [11:0] rpt_peak_pos;

  modport master (output rpt_valid, rpt_start, rpt_width, rpt_peak, rpt_peak_pos,
                  input  rpt_ready);
  modport slave  (input  rpt_valid, rpt_start, rpt_width, rpt_peak, rpt_peak_pos,
                  output rpt_ready);
endinterface

// File: rtl/target_extractor.sv
// rtl/target_extractor.sv - threshold target detector with report FIFO
// Optional exit hysteresis enabled by defining TGT_HYST_EN.
module target_extractor #(
  parameter int RANGE_LIMIT = 4095,
  parameter int MIN_WIDTH   = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int HYST        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trig,
  input  logic [11:0]               vid_in,
  input  logic [11:0]               thr,
  target_extractor_if.master        rpt,
  output logic [7:0]                drop_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [11:0] LIMIT    = 12'(RANGE_LIMIT);
  localparam logic [11:0] MIN_W    = 12'(MIN_WIDTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] IDX_ONE = PW'(1);
`ifdef TGT_HYST_EN
  localparam logic [11:0] HYST_EFF = 12'(HYST);
`else
  // hysteresis disabled: exit threshold collapses onto thr
  localparam logic [11:0] HYST_EFF = 12'(HYST) & 12'h000;
`endif

  typedef enum logic [1:0] {IDLE, SEARCH, IN_TGT} state_t;
  typedef struct packed {
    logic [11:0] start;
    logic [11:0] width;
    logic [11:0] peak;
    logic [11:0] peakPos;
  } report_t;

  state_t      state, nState;
  logic [11:0] rangeCnt;
  logic [11:0] tgtStart, tgtWidth, tgtPeak, tgtPeakPos;
  logic [11:0] nStart, nWidth, nPeak, nPeakPos;
  logic [11:0] bin, exitThr;
  logic        active, lastBin, closeReq, pushReq, wrEn, pop, full, dropEv;
  report_t     closeRpt, head;

  report_t     mem [FIFO_DEPTH];
  logic [PW-1:0] wrIdx, rdIdx;
  logic [PW:0]   count;

  assign exitThr = (thr > HYST_EFF) ? (thr - HYST_EFF) : 12'd0;

  always_comb begin
    bin      = trig ? 12'd0 : rangeCnt;
    active   = trig || (state != IDLE);
    lastBin  = !trig && (rangeCnt == LIMIT);
    nState   = state;
    nStart   = tgtStart;
    nWidth   = tgtWidth;
    nPeak    = tgtPeak;
    nPeakPos = tgtPeakPos;
    closeReq = 1'b0;
    if (active) begin
      // a trig discards the open target and the sample is judged as a fresh search
      if (state == IN_TGT && !trig) begin
        if (vid_in >= exitThr) begin
          nWidth = tgtWidth + 12'd1;
          if (vid_in > tgtPeak) begin
            nPeak    = vid_in;
            nPeakPos = bin;
          end
        end else begin
          closeReq = 1'b1;
          nState   = SEARCH;
        end
      end else if (vid_in >= thr) begin
        nState   = IN_TGT;
        nStart   = bin;
        nWidth   = 12'd1;
        nPeak    = vid_in;
        nPeakPos = bin;
      end else begin
        nState = SEARCH;
      end
      if (lastBin) begin
        if (nState == IN_TGT) closeReq = 1'b1;
        nState = IDLE;
      end
    end
  end

  assign closeRpt = '{start: nStart, width: nWidth, peak: nPeak, peakPos: nPeakPos};
  assign pushReq  = closeReq && (nWidth >= MIN_W);
  assign full     = (count == CNT_FULL);
  assign pop      = rpt.rpt_valid && rpt.rpt_ready;
  assign wrEn     = pushReq && (!full || pop);
  assign dropEv   = pushReq && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rangeCnt   <= '0;
      tgtStart   <= '0;
      tgtWidth   <= '0;
      tgtPeak    <= '0;
      tgtPeakPos <= '0;
      wrIdx      <= '0;
      rdIdx      <= '0;
      count      <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= nState;
      tgtStart   <= nStart;
      tgtWidth   <= nWidth;
      tgtPeak    <= nPeak;
      tgtPeakPos <= nPeakPos;
      if (active) rangeCnt <= lastBin ? rangeCnt : bin + 12'd1;
      if (wrEn) wrIdx <= wrIdx + IDX_ONE;
      if (pop)  rdIdx <= rdIdx + IDX_ONE;
      case ({wrEn, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (dropEv && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrIdx] <= closeRpt;
  end

  assign head             = mem[rdIdx];
  assign rpt.rpt_valid    = (count != '0);
  assign rpt.rpt_start    = rpt.rpt_valid ? head.start   : 12'd0;
  assign rpt.rpt_width    = rpt.rpt_valid ? head.width   : 12'd0;
  assign rpt.rpt_peak     = rpt.rpt_valid ? head.peak    : 12'd0;
  assign rpt.rpt_peak_pos = rpt.rpt_valid ? head.peakPos : 12'd0;
endmodule

// File: tb/tb_target_extractor.sv
// tb/tb_target_extractor.sv - scoreboard bench for target_extractor
module tb_target_extractor;
  localparam int RL = 4095, MINW = 2, DEPTH = 4, HYST = 16;

  typedef struct packed {
    logic [11:0] start;
    logic [11:0] width;
    logic [11:0] peak;
    logic [11:0] pos;
  } rep_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [11:0] vid_in = '0;
  logic [11:0] thr = 12'd100;
  logic [7:0]  drop_cnt;

  target_extractor_if rpt();

  target_extractor #(.RANGE_LIMIT(RL), .MIN_WIDTH(MINW), .FIFO_DEPTH(DEPTH), .HYST(HYST)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .vid_in(vid_in), .thr(thr),
    .rpt(rpt), .drop_cnt(drop_cnt));

  always #10 clk = ~clk;

  rep_t expQ[$];
  int   modelCount = 0;
  int   expDrops = 0;
  bit   expValid = 0;
  int   nCmp = 0;
  int   nFail = 0;
  int   vidArr[4096];
  bit   hasRpt[4096];
  rep_t rptAt[4096];

  function automatic int exitOf(int t);
`ifdef TGT_HYST_EN
    return (t > HYST) ? t - HYST : 0;
`else
    return t;
`endif
  endfunction

  // Each run of samples starting at/above thr and continuing at/above the exit level is a target.
  task automatic planSweep(int len, bit complete);
    int i, s, j, pk, pp, closeAt, th, ex;
    th = int'(thr);
    ex = exitOf(th);
    for (int k = 0; k < len; k++) hasRpt[k] = 0;
    i = 0;
    while (i < len) begin
      if (vidArr[i] < th) begin
        i++;
      end else begin
        s = i; pk = vidArr[s]; pp = s; j = s + 1;
        while (j < len && vidArr[j] >= ex) begin
          if (vidArr[j] > pk) begin pk = vidArr[j]; pp = j; end
          j++;
        end
        closeAt = (j < len) ? j : (complete ? len - 1 : -1);
        if (closeAt >= 0 && (j - s) >= MINW) begin
          hasRpt[closeAt] = 1;
          rptAt[closeAt] = '{start: 12'(s), width: 12'(j - s), peak: 12'(pk), pos: 12'(pp)};
        end
        i = j;
      end
    end
  endtask

  task automatic step(bit t, int v, bit rdy, bit push, rep_t r);
    bit popNow;
    trig = t;
    vid_in = 12'(v);
    rpt.rpt_ready = rdy;
    expValid = (modelCount > 0);
    popNow = expValid && rdy;
    if (push) begin
      if (modelCount < DEPTH || popNow) begin
        expQ.push_back(r);
        modelCount++;
      end else if (expDrops < 255) begin
        expDrops++;
      end
    end
    if (popNow) modelCount--;
    @(posedge clk); #1;
  endtask

  function automatic bit readyFor(int mode, int i, int idx);
    case (mode)
      1: return 1'b0;
      2: return 1'b1;
      3: return (i == idx);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic runSweep(int len, bit complete, int rmode, int ridx);
    if (complete) len = RL + 1;
    planSweep(len, complete);
    for (int i = 0; i < len; i++) step(i == 0, vidArr[i], readyFor(rmode, i, ridx), hasRpt[i], rptAt[i]);
  endtask

  task automatic idleCycles(int n, int rmode);
    rep_t z;
    z = '0;
    for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(0, 4095)), readyFor(rmode, i, -1), 1'b0, z);
  endtask

  task automatic clearArr(int len);
    for (int i = 0; i < len; i++) vidArr[i] = 0;
  endtask

  task automatic fillRandom(int len);
    bit hi;
    int th, lo;
    th = int'(thr);
    lo = (th > 20) ? th - 20 : 0;
    hi = 0;
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) hi = !hi;
      if (hi) vidArr[i] = ($urandom_range(0, 1) == 1) ? th + int'($urandom_range(0, 3)) : int'($urandom_range(th, 4095));
      else    vidArr[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(lo, th - 1)) : int'($urandom_range(0, th - 1));
    end
  endtask

  task automatic check(string name, int got, int want);
    nCmp++;
    if (got != want) begin
      nFail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: compares the presented report against the scoreboard head every cycle.
  initial begin
    rep_t got;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        nCmp++;
        if (rpt.rpt_valid !== expValid) begin
          nFail++;
          $display("FAIL rpt_valid at %0t: got %b want %b", $time, rpt.rpt_valid, expValid);
        end
        if (rpt.rpt_valid === 1'b1) begin
          nCmp++;
          if (expQ.size() == 0) begin
            nFail++;
            $display("FAIL unexpected report at %0t: got start=%0d width=%0d", $time, rpt.rpt_start, rpt.rpt_width);
          end else begin
            got = '{start: rpt.rpt_start, width: rpt.rpt_width, peak: rpt.rpt_peak, pos: rpt.rpt_peak_pos};
            if (got !== expQ[0]) begin
              nFail++;
              $display("FAIL report at %0t: got start=%0d width=%0d peak=%0d pos=%0d want start=%0d width=%0d peak=%0d pos=%0d",
                       $time, got.start, got.width, got.peak, got.pos,
                       expQ[0].start, expQ[0].width, expQ[0].peak, expQ[0].pos);
            end
            if (rpt.rpt_ready === 1'b1) void'(expQ.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rpt.rpt_ready = 1'b0;
    trig = 1'b1;
    vid_in = 12'd4000;
    repeat (3) @(posedge clk);
    #1;
    check("reset rpt_valid", int'(rpt.rpt_valid), 0);
    check("reset rpt_start", int'(rpt.rpt_start), 0);
    check("reset rpt_width", int'(rpt.rpt_width), 0);
    check("reset rpt_peak", int'(rpt.rpt_peak), 0);
    check("reset rpt_peak_pos", int'(rpt.rpt_peak_pos), 0);
    check("reset drop_cnt", int'(drop_cnt), 0);
    trig = 1'b0;
    vid_in = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic target with a tied peak
    thr = 12'd100;
    clearArr(40);
    vidArr[10] = 150; vidArr[11] = 300; vidArr[12] = 300; vidArr[13] = 120;
    runSweep(40, 0, 2, -1);

    // single-bin target below MIN_WIDTH
    clearArr(40);
    vidArr[20] = 500;
    runSweep(40, 0, 2, -1);
    check("drop_cnt after narrow target", int'(drop_cnt), expDrops);

    // trig while a target is open, then a target proving range restarted
    clearArr(8);
    vidArr[5] = 200; vidArr[6] = 200; vidArr[7] = 200;
    runSweep(8, 0, 2, -1);
    clearArr(20);
    vidArr[3] = 250; vidArr[4] = 260; vidArr[5] = 250;
    runSweep(20, 0, 2, -1);

    // hysteresis pattern
    clearArr(10);
    vidArr[2] = 120; vidArr[3] = 90; vidArr[4] = 110; vidArr[5] = 80;
    runSweep(10, 0, 2, -1);

    // six targets into a stalled FIFO, then simultaneous pop and push when full
    clearArr(40);
    for (int k = 0; k < 6; k++) begin
      vidArr[2 + 4 * k] = 200 + k;
      vidArr[3 + 4 * k] = 300 + k;
    end
    runSweep(40, 0, 1, -1);
    check("drop_cnt after overflow", int'(drop_cnt), expDrops);
    clearArr(12);
    vidArr[2] = 400; vidArr[3] = 410; vidArr[4] = 405;
    runSweep(12, 0, 3, 5);
    check("drop_cnt after pop+push when full", int'(drop_cnt), expDrops);
    clearArr(20);
    runSweep(20, 0, 2, -1);

    // target running into RANGE_LIMIT, then ignored samples while idle
    clearArr(RL + 1);
    for (int k = 4090; k <= RL; k++) vidArr[k] = 150 + int'($urandom_range(0, 500));
    runSweep(RL + 1, 1, 0, -1);
    idleCycles(30, 2);

    // randomized sweeps
    for (int n = 0; n < 50; n++) begin
      thr = 12'($urandom_range(1, 4000));
      fillRandom(300);
      runSweep(int'($urandom_range(10, 300)), 0, ($urandom_range(0, 4) == 0) ? 1 : 0, -1);
    end
    for (int n = 0; n < 2; n++) begin
      thr = 12'($urandom_range(1, 4000));
      fillRandom(RL + 1);
      runSweep(RL + 1, 1, 0, -1);
      idleCycles(20, 0);
    end

    thr = 12'd100;
    clearArr(30);
    runSweep(30, 0, 2, -1);
    check("scoreboard empty at end", expQ.size(), 0);
    check("final drop_cnt", int'(drop_cnt), expDrops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
